// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared definitions for the MIPS-style ALU.
//   - OP_* : 4-bit opcode constants used by the datapath and by benches.
//   - alu_out_t : bundle of everything the ALU produces for one operation
//                 (high word, low word, carry, sign, zero).
package mips_alu_pkg;

  localparam logic [3:0] OP_PASSA = 4'h0;
  localparam logic [3:0] OP_NOT   = 4'h1;
  localparam logic [3:0] OP_INC   = 4'h2;
  localparam logic [3:0] OP_DEC   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_MUL   = 4'hB;
  localparam logic [3:0] OP_SAR   = 4'hC;
  localparam logic [3:0] OP_NEG   = 4'hD;
  localparam logic [3:0] OP_SLT   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  typedef struct packed {
    logic [31:0] hi;     // high word, nonzero only for MUL
    logic [31:0] lo;     // low word / main result
    logic        carry;  // carry, borrow or last shifted-out bit
    logic        sign;
    logic        zero;
  } alu_out_t;

endpackage

// File: rtl/mips_alu_comb.sv
// mips_alu_comb: purely combinational ALU datapath, no clock.
// Ports:
//   a, b : 32-bit operands (b[4:0] is the shift amount for shifts)
//   op   : 4-bit opcode (OP_* from mips_alu_pkg)
//   res  : alu_out_t with hi/lo words and carry/sign/zero flags
module mips_alu_comb
  import mips_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output alu_out_t    res
);

  logic [4:0]  shamt;
  logic [5:0]  shl_idx;
  logic [63:0] prod;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        carry;

  assign shamt   = b[4:0];
  // Bit of a that leaves position 31 last on a left shift by shamt.
  assign shl_idx = 6'd32 - {1'b0, shamt};
  assign prod    = {32'd0, a} * {32'd0, b};

  always_comb begin
    hi    = '0;
    lo    = '0;
    carry = 1'b0;
    case (op)
      OP_PASSA: lo = a;
      OP_NOT:   lo = ~a;
      OP_INC:   {carry, lo} = {1'b0, a} + 33'd1;
      OP_DEC: begin
        lo    = a - 32'd1;
        carry = (a == 32'd0);
      end
      OP_ADD:   {carry, lo} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        lo    = a - b;
        carry = (a < b);
      end
      OP_AND:   lo = a & b;
      OP_OR:    lo = a | b;
      OP_XOR:   lo = a ^ b;
      OP_SHL: begin
        lo    = a << shamt;
        carry = (shamt != 5'd0) ? a[shl_idx[4:0]] : 1'b0;
      end
      OP_SHR: begin
        lo    = a >> shamt;
        carry = (shamt != 5'd0) ? a[shamt - 5'd1] : 1'b0;
      end
      OP_MUL: begin
        hi    = prod[63:32];
        lo    = prod[31:0];
        carry = (prod[63:32] != 32'd0);
      end
      OP_SAR: begin
        lo    = $unsigned($signed(a) >>> shamt);
        carry = (shamt != 5'd0) ? a[shamt - 5'd1] : 1'b0;
      end
      OP_NEG: begin
        lo    = 32'd0 - a;
        carry = (a != 32'd0);  // 0 - a borrows for any nonzero a
      end
      OP_SLT:   lo = {31'd0, ($signed(a) < $signed(b))};
      OP_PASSB: lo = b;
      default:  lo = '0;
    endcase
  end

  always_comb begin
    res       = '0;
    res.hi    = hi;
    res.lo    = lo;
    res.carry = carry;
    // MUL flags describe the full 64-bit product.
    if (op == OP_MUL) begin
      res.sign = hi[31];
      res.zero = ({hi, lo} == 64'd0);
    end else begin
      res.sign = lo[31];
      res.zero = (lo == 32'd0);
    end
  end

endmodule

// File: rtl/mips_alu.sv
// mips_alu: MIPS-style ALU with registered outputs, 1-cycle latency.
// A new operation may be presented every cycle; there is no handshake:
// inputs sampled at rising edge N appear on the outputs right after edge N.
// Ports:
//   clk       : clock, outputs update on its rising edge
//   rst       : asynchronous active-low reset, clears all outputs
//   a, b      : 32-bit operands
//   opSel     : 4-bit opcode (OP_* from mips_alu_pkg)
//   result    : low word of the result
//   resultExt : high word of the result (MUL only, else 0)
//   carryFlag, signFlag, zeroFlag : registered flags
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  opSel,
  output logic [31:0] result,
  output logic [31:0] resultExt,
  output logic        carryFlag,
  output logic        signFlag,
  output logic        zeroFlag
);

  alu_out_t nxt;
  alu_out_t q;

  mips_alu_comb u_comb (
    .a   (a),
    .b   (b),
    .op  (opSel),
    .res (nxt)
  );

  // The five output registers are the only state in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= nxt;
  end

  assign result    = q.lo;
  assign resultExt = q.hi;
  assign carryFlag = q.carry;
  assign signFlag  = q.sign;
  assign zeroFlag  = q.zero;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: self-checking bench for mips_alu with an expected-value queue.
module tb_mips_alu;
  import mips_alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op_sel = '0;
  logic [31:0] result;
  logic [31:0] result_ext;
  logic        carry_flag;
  logic        sign_flag;
  logic        zero_flag;

  always #5 clk = ~clk;

  mips_alu dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .opSel     (op_sel),
    .result    (result),
    .resultExt (result_ext),
    .carryFlag (carry_flag),
    .signFlag  (sign_flag),
    .zeroFlag  (zero_flag)
  );

  // ---------------- scoreboard ----------------
  logic [66:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built on 64-bit arithmetic.
  function automatic alu_out_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    alu_out_t    r;
    logic [63:0] w;
    logic [4:0]  n;
    r = '0;
    w = '0;
    n = y[4:0];
    case (op)
      OP_PASSA: r.lo = x;
      OP_NOT:   r.lo = ~x;
      OP_INC:   begin w = {32'd0, x} + 64'd1;          r.lo = w[31:0]; r.carry = w[32]; end
      OP_DEC:   begin w = {32'd0, x} - 64'd1;          r.lo = w[31:0]; r.carry = w[63]; end
      OP_ADD:   begin w = {32'd0, x} + {32'd0, y};     r.lo = w[31:0]; r.carry = w[32]; end
      OP_SUB:   begin w = {32'd0, x} - {32'd0, y};     r.lo = w[31:0]; r.carry = w[63]; end
      OP_AND:   r.lo = x & y;
      OP_OR:    r.lo = x | y;
      OP_XOR:   r.lo = x ^ y;
      OP_SHL:   begin w = {32'd0, x} << n;             r.lo = w[31:0];  r.carry = w[32]; end
      OP_SHR:   begin w = {x, 32'd0} >> n;             r.lo = w[63:32]; r.carry = w[31]; end
      OP_SAR:   begin w = $unsigned($signed({x, 32'd0}) >>> n); r.lo = w[63:32]; r.carry = w[31]; end
      OP_MUL:   begin w = {32'd0, x} * {32'd0, y}; r.hi = w[63:32]; r.lo = w[31:0]; r.carry = |w[63:32]; end
      OP_NEG:   begin w = 64'd0 - {32'd0, x};          r.lo = w[31:0]; r.carry = w[63]; end
      OP_SLT:   r.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_PASSB: r.lo = y;
      default:  r = '0;
    endcase
    if (op == OP_MUL) begin
      r.sign = r.hi[31];
      r.zero = ({r.hi, r.lo} == 64'd0);
    end else begin
      r.sign = r.lo[31];
      r.zero = (r.lo == 32'd0);
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive on the falling edge, push expectation, compare 1 ns after the next rising edge.
  task automatic run_exp(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input alu_out_t e);
    alu_out_t got;
    alu_out_t want;
    @(negedge clk);
    op_sel = op;
    a      = x;
    b      = y;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = '{hi: result_ext, lo: result, carry: carry_flag, sign: sign_flag, zero: zero_flag};
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      want = exp_q.pop_front();
      check({tag, "_word"},  {got.hi, got.lo}, {want.hi, want.lo});
      check({tag, "_flags"}, {61'd0, got.carry, got.sign, got.zero},
                             {61'd0, want.carry, want.sign, want.zero});
    end
  endtask

  task automatic run_model(input string tag, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y);
    run_exp(tag, op, x, y, model(op, x, y));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"},  {result_ext, result}, 64'd0);
    check({tag, "_flags"}, {61'd0, carry_flag, sign_flag, zero_flag}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset held with live inputs: outputs stay zero across edges.
    op_sel = OP_ADD;
    a      = 32'h1234_5678;
    b      = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors with hand-derived expectations {hi, lo, C, S, Z}.
    run_exp("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1,      {32'h0, 32'h0, 1'b1, 1'b0, 1'b1});
    run_exp("sub_neg",  OP_SUB, 32'h5, 32'h7,               {32'h0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0});
    run_exp("mul_max",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h1, 1'b1, 1'b1, 1'b0});
    run_exp("mul_zero", OP_MUL, 32'h0, 32'h1234,            {32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    run_exp("mul_small",OP_MUL, 32'h10, 32'h20,             {32'h0, 32'h200, 1'b0, 1'b0, 1'b0});
    run_exp("shl_out",  OP_SHL, 32'h8000_0001, 32'd1,       {32'h0, 32'h2, 1'b1, 1'b0, 1'b0});
    run_exp("sar_31",   OP_SAR, 32'h8000_0000, 32'd31,      {32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0});
    run_exp("shr_0",    OP_SHR, 32'h3, 32'd0,               {32'h0, 32'h3, 1'b0, 1'b0, 1'b0});
    run_exp("shr_1",    OP_SHR, 32'h3, 32'd1,               {32'h0, 32'h1, 1'b1, 1'b0, 1'b0});
    run_exp("shl_0",    OP_SHL, 32'h8000_0001, 32'h20,      {32'h0, 32'h8000_0001, 1'b0, 1'b1, 1'b0});
    run_exp("sar_0",    OP_SAR, 32'hF000_000F, 32'd0,       {32'h0, 32'hF000_000F, 1'b0, 1'b1, 1'b0});
    run_exp("slt_lt",   OP_SLT, 32'hFFFF_FFFF, 32'h1,       {32'h0, 32'h1, 1'b0, 1'b0, 1'b0});
    run_exp("slt_ge",   OP_SLT, 32'h1, 32'hFFFF_FFFF,       {32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    run_exp("inc_wrap", OP_INC, 32'hFFFF_FFFF, 32'h0,       {32'h0, 32'h0, 1'b1, 1'b0, 1'b1});
    run_exp("dec_wrap", OP_DEC, 32'h0, 32'h0,               {32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0});
    run_exp("neg_one",  OP_NEG, 32'h1, 32'h0,               {32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0});
    run_exp("neg_zero", OP_NEG, 32'h0, 32'h0,               {32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    run_exp("passb",    OP_PASSB, 32'h0, 32'hCAFE_0000,     {32'h0, 32'hCAFE_0000, 1'b0, 1'b1, 1'b0});

    // Every opcode once with random operands, then a random mix.
    for (int i = 0; i < 16; i++) begin
      run_model("sweep", 4'(i), $urandom, $urandom);
    end
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      run_model("rand", rop, ra, rb);
    end

    // Reset mid-stream: back-to-back ADDs, then async reset between edges.
    run_exp("pre_rst0", OP_ADD, 32'h100, 32'h23, {32'h0, 32'h123, 1'b0, 1'b0, 1'b0});
    run_exp("pre_rst1", OP_ADD, 32'h8000_0000, 32'h1, {32'h0, 32'h8000_0001, 1'b0, 1'b1, 1'b0});
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    op_sel = OP_ADD;
    a      = 32'hFFFF_FFFF;
    b      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check_zero("rst_edge_discard");
    @(negedge clk);
    rst = 1'b1;
    run_exp("post_rst", OP_ADD, 32'd10, 32'd20, {32'h0, 32'd30, 1'b0, 1'b0, 1'b0});

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
- REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all outputs update on its rising edge.
- REQ-002 SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
- REQ-003 SHALL have port `a`, input, 32 bits: operand A.
- REQ-004 SHALL have port `b`, input, 32 bits: operand B; for shifts only b[4:0] is the shift amount.
- REQ-005 SHALL have port `opSel`, input, 4 bits: operation select per REQ-010.
- REQ-006 SHALL have port `result`, output, 32 bits: registered low word of the result.
- REQ-007 SHALL have port `resultExt`, output, 32 bits: registered high word of the result; nonzero only for MUL.
- REQ-008 SHALL have port `carryFlag`, output, 1 bit: registered carry/borrow/shift-out flag.
- REQ-009 SHALL have ports `signFlag` and `zeroFlag`, outputs, 1 bit each: registered sign and zero flags.

Function
- REQ-010 SHALL decode `opSel` as follows:
  - 0 PASSA: result = a.
  - 1 NOT: result = ~a.
  - 2 INC: result = a+1.
  - 3 DEC: result = a-1.
  - 4 ADD: result = a+b.
  - 5 SUB: result = a-b.
  - 6 AND, 7 OR, 8 XOR: bitwise a op b.
  - 9 SHL: logical left shift of a by b[4:0].
  - A SHR: logical right shift of a by b[4:0].
  - B MUL: unsigned a*b, giving the 64-bit {resultExt,result}.
  - C SAR: arithmetic right shift of a by b[4:0].
  - D NEG: result = 0-a.
  - E SLT: result = 1 if signed a < signed b, else 0.
  - F PASSB: result = b.
- REQ-011 SHALL be fully combinational from inputs to next-state, with registered outputs: inputs present before rising edge N appear on the outputs after edge N (1-cycle latency, new operation every cycle, no handshake).
- REQ-012 SHALL drive resultExt = 0 for every opcode except MUL.
- REQ-013 SHALL set carryFlag as follows:
  - ADD/INC: carry out of bit 31.
  - SUB/DEC/NEG: borrow (1 when the unsigned minuend < subtrahend).
  - SHL: last bit shifted out of bit 31.
  - SHR/SAR: last bit shifted out of bit 0.
  - MUL: 1 when the high word is nonzero.
  - All others: 0.
- REQ-014 SHALL clear carryFlag for any shift by 0; the result is then equal to a.
- REQ-015 SHALL set signFlag = result[31], except MUL, where signFlag = resultExt[31].
- REQ-016 SHALL set zeroFlag = 1 when result == 0, except MUL, where zeroFlag = 1 only when the full 64-bit product == 0.
- REQ-017 SHALL wrap all 32-bit arithmetic modulo 2^32, with no overflow trap.

Reset
- REQ-018 SHALL, while rst = 0, immediately (asynchronously) force result, resultExt, carryFlag, signFlag and zeroFlag to 0.
- REQ-019 SHALL hold these reset values until the first rising clk edge after rst returns to 1; that edge captures the current inputs normally.
- REQ-020 SHALL discard any operation whose capturing edge coincides with rst = 0, with no residual state.

Structure
- REQ-021 SHALL take its opcode constants (OP_PASSA..OP_PASSB, 4-bit) from a shared package, mips_alu_pkg, used by the decoder and testbenches.
- REQ-022 SHALL implement the combinational datapath as one sub-module, mips_alu_comb (no clock); mips_alu adds only the output registers and reset.
- REQ-023 SHALL have no state other than the five output registers.

Verification
- REQ-024 ADD: a=FFFFFFFF, b=00000001, op=4 -> after one edge: result=00000000, resultExt=0, C=1, S=0, Z=1.
- REQ-025 SUB: a=00000005, b=00000007, op=5 -> result=FFFFFFFE, C=1, S=1, Z=0.
- REQ-026 MUL: a=FFFFFFFF, b=FFFFFFFF, op=B -> resultExt=FFFFFFFE, result=00000001, C=1, S=1, Z=0. Also a=0, b=1234 -> all zero, Z=1.
- REQ-027 Shifts:
  - SHL a=80000001, b=1 -> result=00000002, C=1.
  - SAR a=80000000, b=31 -> result=FFFFFFFF, S=1.
  - SHR a=00000003, b=0 -> result=00000003, C=0.
- REQ-028 SLT: a=FFFFFFFF, b=00000001, op=E -> result=1. Swapping the operands -> result=0, Z=1.
- REQ-029 Reset mid-stream: drive ADD results back-to-back, then pull rst low between edges -> all outputs 0 immediately, with no clock edge needed. Release rst -> the first edge shows the current inputs' result.
